// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: sequences LSU data-memory accesses. Word stores are written
// straight through, byte stores do read / merge / write-back, loads return the
// read word. One access is in flight at a time.
module store_rmw_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic                  req_byte,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_WAIT  = 3'd3,
    S_MERGE = 3'd4
  } state_t;

  // Wait cycles after the read strobe before mem_rdata is valid.
  localparam logic [2:0] LAT_M1 = 3'(RD_LATENCY - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;
  logic                  r_store;
  logic                  r_byte;
  logic [1:0]            r_lane;
  logic [7:0]            r_bdata;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [DATA_WIDTH-1:0] r_rsp_hold;
  logic                  w_accept;
  logic                  w_rd_done;
  logic                  w_en_nxt;
  logic                  w_we_nxt;
  logic                  w_done_nxt;
  logic                  w_load_hit;
  logic [DATA_WIDTH-1:0] w_merged;

  // Replace one byte lane of a word (lane 0 = [7:0] ... lane 3 = [31:24]).
  function automatic logic [DATA_WIDTH-1:0] merge_byte(
    input logic [DATA_WIDTH-1:0] word,
    input logic [1:0]            lane,
    input logic [7:0]            b
  );
    logic [DATA_WIDTH-1:0] res;
    res = word;
    case (lane)
      2'd0:    res[7:0]   = b;
      2'd1:    res[15:8]  = b;
      2'd2:    res[23:16] = b;
      default: res[31:24] = b;
    endcase
    return res;
  endfunction

  assign w_merged   = merge_byte(mem_rdata, r_lane, r_bdata);
  assign w_load_hit = (r_state == S_WAIT) && (r_cnt == 3'd0) && !r_store;

  assign req_ready = (r_state == S_IDLE);
  assign done      = r_done;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  // Load data is passed straight through in its completion cycle, then held.
  assign rsp_rdata = w_load_hit ? mem_rdata : r_rsp_hold;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state, counter and next values of the registered memory-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_rd_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = (req_store && !req_byte) ? S_WRITE : S_READ;
        end
      end
      S_WRITE: w_state_nxt = S_IDLE;
      S_READ: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = LAT_M1;
      end
      S_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_rd_done   = 1'b1;
          w_state_nxt = (r_store && r_byte) ? S_MERGE : S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      S_MERGE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_en_nxt   = (w_state_nxt == S_WRITE) || (w_state_nxt == S_READ) ||
                 (w_state_nxt == S_MERGE);
    w_we_nxt   = (w_state_nxt == S_WRITE) || (w_state_nxt == S_MERGE);
    // A load completes in the WAIT cycle whose counter reads zero.
    w_done_nxt = w_we_nxt ||
                 ((w_state_nxt == S_WAIT) && (w_cnt_nxt == 3'd0) && !r_store);
  end

  // Request capture, latency counter and registered memory/response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= 3'd0;
      r_store     <= 1'b0;
      r_byte      <= 1'b0;
      r_lane      <= 2'd0;
      r_bdata     <= 8'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_done      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_hold  <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_mem_en <= w_en_nxt;
      r_mem_we <= w_we_nxt;
      r_done   <= w_done_nxt;
      if (w_accept) begin
        r_store    <= req_store;
        r_byte     <= req_byte;
        r_lane     <= req_addr[1:0];
        r_bdata    <= req_wdata[7:0];
        r_mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (req_store && !req_byte) r_mem_wdata <= req_wdata;
      end
      if (w_rd_done && r_store && r_byte) r_mem_wdata <= w_merged;
      if (w_load_hit) r_rsp_hold <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: two instances (read latency 1 and 3), each with a
// behavioural memory; expected completions are queued at issue and checked on done.
module tb_store_rmw_ctrl;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0]       req_store = '0;
  logic [1:0]       req_byte = '0;
  logic [1:0][31:0] req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [1:0]       done;
  logic [1:0][31:0] rsp_rdata;
  logic [1:0]       mem_en;
  logic [1:0]       mem_we;
  logic [1:0][31:0] mem_addr;
  logic [1:0][31:0] mem_wdata;
  logic [1:0][31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  localparam logic [31:0] POISON = 32'hBAD0BAD0;

  store_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_store(req_store[0]), .req_byte(req_byte[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .done(done[0]), .rsp_rdata(rsp_rdata[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  store_rmw_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .RD_LATENCY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_store(req_store[1]), .req_byte(req_byte[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .done(done[1]), .rsp_rdata(rsp_rdata[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural synchronous memories; read data appears RD_LATENCY cycles after the strobe.
  logic [31:0] mem0 [0:63] = '{default: '0};
  logic [31:0] mem1 [0:63] = '{default: '0};
  logic [31:0] pipe0 [0:7] = '{default: '0};
  logic [31:0] pipe1 [0:7] = '{default: '0};

  always @(posedge clk) begin
    if (mem_en[0] && mem_we[0]) mem0[mem_addr[0][7:2]] <= mem_wdata[0];
    pipe0[0] <= (mem_en[0] && !mem_we[0]) ? mem0[mem_addr[0][7:2]] : POISON;
    for (int k = 1; k < 8; k++) pipe0[k] <= pipe0[k-1];
  end

  always @(posedge clk) begin
    if (mem_en[1] && mem_we[1]) mem1[mem_addr[1][7:2]] <= mem_wdata[1];
    pipe1[0] <= (mem_en[1] && !mem_we[1]) ? mem1[mem_addr[1][7:2]] : POISON;
    for (int k = 1; k < 8; k++) pipe1[k] <= pipe1[k-1];
  end

  assign mem_rdata[0] = pipe0[0];
  assign mem_rdata[1] = pipe1[2];

  // Watch window for the abandoned-request check.
  logic watch = 1'b0;
  logic we_seen = 1'b0;
  logic done_seen = 1'b0;
  always @(posedge clk) begin
    if (watch && mem_we[1]) we_seen <= 1'b1;
    if (watch && done[1])   done_seen <= 1'b1;
  end

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] refm [2][64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_merge(input logic [31:0] w, input logic [1:0] lane,
                                            input logic [7:0] b);
    logic [31:0] mask;
    mask = 32'hFF << (8 * lane);
    return (w & ~mask) | ({24'd0, b} << (8 * lane));
  endfunction

  // mode 0: drop valid after accept; 1: hold valid until done; 2: random noise while busy
  task automatic do_req(input int u, input bit st, input bit by, input logic [31:0] a,
                        input logic [31:0] d, input int mode, input string tag);
    exp_t e;
    exp_t got;
    int   t0;
    int   lat;
    bit   seen;
    bit   early_we;
    lat = (u == 0) ? 1 : 3;
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready[u]; k++) @(negedge clk);
    chk({tag, "_ready"}, {31'd0, req_ready[u]}, 32'd1);
    req_valid[u] = 1'b1;
    req_store[u] = st;
    req_byte[u]  = by;
    req_addr[u]  = a;
    req_wdata[u] = d;
    t0 = cyc;
    e.addr = {a[31:2], 2'b00};
    if (!st) begin
      e.is_load = 1'b1;
      e.data    = refm[u][a[7:2]];
      e.due     = t0 + 1 + lat;
    end else if (!by) begin
      e.is_load = 1'b0;
      e.data    = d;
      e.due     = t0 + 1;
      refm[u][a[7:2]] = d;
    end else begin
      e.is_load = 1'b0;
      e.data    = ref_merge(refm[u][a[7:2]], a[1:0], d[7:0]);
      e.due     = t0 + 2 + lat;
      refm[u][a[7:2]] = e.data;
    end
    sbq.push_back(e);
    seen = 1'b0;
    early_we = 1'b0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (mode == 0) req_valid[u] = 1'b0;
      else if (mode == 2) begin
        req_valid[u] = 1'($urandom_range(1, 0));
        req_store[u] = 1'($urandom_range(1, 0));
        req_addr[u]  = $urandom;
        req_wdata[u] = $urandom;
      end
      if (k == 1 && (!st || by)) begin
        chk({tag, "_rd_strobe"}, {30'd0, mem_en[u], mem_we[u]}, 32'd2);
        chk({tag, "_rd_addr"}, mem_addr[u], e.addr);
      end
      if (mode == 1) chk({tag, "_busy_ready"}, {31'd0, req_ready[u]}, 32'd0);
      if (done[u]) begin
        seen = 1'b1;
        req_valid[u] = 1'b0;
        got = sbq.pop_front();
        chk({tag, "_done_cycle"}, 32'(cyc), 32'(got.due));
        if (got.is_load) begin
          chk({tag, "_rdata"}, rsp_rdata[u], got.data);
          chk({tag, "_ld_we"}, {31'd0, mem_we[u]}, 32'd0);
        end else begin
          chk({tag, "_wr_strobe"}, {30'd0, mem_en[u], mem_we[u]}, 32'd3);
          chk({tag, "_wr_addr"}, mem_addr[u], got.addr);
          chk({tag, "_wr_data"}, mem_wdata[u], got.data);
        end
      end else if (mem_we[u]) begin
        early_we = 1'b1;
      end
    end
    if (!seen) begin
      req_valid[u] = 1'b0;
      void'(sbq.pop_front());
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end
    if (by && st) chk({tag, "_no_early_we"}, {31'd0, early_we}, 32'd0);
    if (mode == 1) begin
      @(negedge clk);
      chk({tag, "_ready_after"}, {31'd0, req_ready[u]}, 32'd1);
      chk({tag, "_ready_cycle"}, 32'(cyc), 32'(e.due + 1));
    end
  endtask

  task automatic chk_reset_outputs(input int u, input string tag);
    chk({tag, "_ready"}, {31'd0, req_ready[u]}, 32'd1);
    chk({tag, "_ctl"}, {29'd0, done[u], mem_en[u], mem_we[u]}, 32'd0);
    chk({tag, "_addr"}, mem_addr[u], 32'd0);
    chk({tag, "_wdata"}, mem_wdata[u], 32'd0);
    chk({tag, "_rsp"}, rsp_rdata[u], 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    for (int u = 0; u < 2; u++)
      for (int i = 0; i < 64; i++) refm[u][i] = 32'd0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0, "rst0");
    chk_reset_outputs(1, "rst1");
    rst_n = 1'b1;

    // Word store, then ready exactly two cycles after acceptance.
    do_req(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 0, "sw10");
    @(negedge clk);
    chk("sw10_ready_t2", {31'd0, req_ready[0]}, 32'd1);

    // Byte store into a preloaded word, latency 1.
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h11223344, 0, "sw20");
    do_req(0, 1'b1, 1'b1, 32'h22, 32'h000000AB, 0, "sb22");
    do_req(0, 1'b0, 1'b0, 32'h20, 32'h0, 0, "lw20");
    chk("lw20_const", rsp_rdata[0], 32'h11AB3344);

    // Load with latency 3 and valid held throughout.
    do_req(1, 1'b1, 1'b0, 32'h20, 32'h11223344, 0, "sw20_l3");
    do_req(1, 1'b0, 1'b0, 32'h20, 32'h0, 1, "lw20_l3");
    chk("lw20_l3_const", rsp_rdata[1], 32'h11223344);

    // Four back-to-back byte stores filling one word.
    for (int i = 0; i < 4; i++)
      do_req(0, 1'b1, 1'b1, 32'h30 + i, 32'(i + 1), 0, $sformatf("sb3%0d", i));
    do_req(0, 1'b0, 1'b0, 32'h30, 32'h0, 0, "lw30");
    chk("lw30_const", rsp_rdata[0], 32'h04030201);
    // Load data holds across a following store.
    do_req(0, 1'b1, 1'b0, 32'h14, 32'hCAFEF00D, 0, "sw14");
    chk("rsp_hold", rsp_rdata[0], 32'h04030201);

    // Input noise while busy must not disturb the captured request.
    do_req(1, 1'b1, 1'b0, 32'h50, 32'h0BADC0DE, 2, "sw50_noise");
    do_req(1, 1'b1, 1'b1, 32'h53, 32'h000000EE, 2, "sb53_noise");
    do_req(1, 1'b0, 1'b0, 32'h50, 32'h0, 2, "lw50_noise");
    chk("lw50_const", rsp_rdata[1], 32'hEEADC0DE);

    // Reset during the WAIT of a byte store abandons it.
    @(negedge clk);
    for (int k = 0; k < 20 && !req_ready[1]; k++) @(negedge clk);
    watch = 1'b1;
    req_valid[1] = 1'b1; req_store[1] = 1'b1; req_byte[1] = 1'b0; req_byte[1] = 1'b1;
    req_addr[1] = 32'h44; req_wdata[1] = 32'h5A;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs(1, "midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    watch = 1'b0;
    chk("midrst_we_seen", {31'd0, we_seen}, 32'd0);
    chk("midrst_done_seen", {31'd0, done_seen}, 32'd0);
    chk("midrst_idle", {31'd0, req_ready[1]}, 32'd1);
    do_req(1, 1'b0, 1'b0, 32'h44, 32'h0, 0, "lw44_after");
    chk("lw44_const", rsp_rdata[1], 32'h0);
    do_req(1, 1'b0, 1'b0, 32'h20, 32'h0, 0, "lw20_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
